coef_bank_seq: RTL and testbench

//  Parametrised coefficient bank and sequencer for the recursive (IIR) filter datapath.

---
 rtl/coef_bank_seq_if.sv | 47 ++++
 rtl/coef_bank_seq.sv | 176 +++++++++++++++++
 tb/tb_coef_bank_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_bank_seq_if.sv
// ---------------------------------------------------------------------------
// coef_bank_seq_if
// Bundles every signal of the coefficient bank/sequencer except clk and rst.
//   sel        band select, sampled on an accepted start
//   start      one-cycle request to stream one frame of coefficients
//   coef_data  current coefficient (registered)
//   coef_idx   index of coef_data within the band
//   coef_valid coef_data/coef_idx/coef_last are valid
//   coef_last  high with the beat of index NCOEF-1
//   coef_ready consumer accepts the beat when coef_valid & coef_ready
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse after the last beat is accepted
//   wr_en / wr_band / wr_idx / wr_data   coefficient table write port
// master: the controller/consumer side; slave: the coef_bank_seq side.
// ---------------------------------------------------------------------------
interface coef_bank_seq_if #(
    parameter int WIDTH  = 22,
    parameter int NCOEF  = 5,
    parameter int NBANDS = 4
);
    localparam int IW = (NCOEF  > 1) ? $clog2(NCOEF)  : 1;
    localparam int BW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

    logic [BW-1:0]    sel;
    logic             start;
    logic [WIDTH-1:0] coef_data;
    logic [IW-1:0]    coef_idx;
    logic             coef_valid;
    logic             coef_last;
    logic             coef_ready;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic [BW-1:0]    wr_band;
    logic [IW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output sel, start, coef_ready, wr_en, wr_band, wr_idx, wr_data,
        input  coef_data, coef_idx, coef_valid, coef_last, busy, done
    );

    modport slave (
        input  sel, start, coef_ready, wr_en, wr_band, wr_idx, wr_data,
        output coef_data, coef_idx, coef_valid, coef_last, busy, done
    );
endinterface

// File: rtl/coef_bank_seq.sv
// ---------------------------------------------------------------------------
// coef_bank_seq
// Coefficient bank and sequencer for the IIR filter datapath. Holds an
// NBANDS x NCOEF table of WIDTH-bit coefficients (writable at any time) and,
// on an accepted start, streams the selected band's coefficients in index
// order over a valid/ready handshake, then pulses done.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (FSM idle, outputs 0, table defaults)
//   bus  coef_bank_seq_if.slave: start/sel request, coefficient stream,
//        busy/done status and table write port
// ---------------------------------------------------------------------------
module coef_bank_seq #(
    parameter int WIDTH  = 22,
    parameter int NCOEF  = 5,
    parameter int NBANDS = 4
) (
    input  logic           clk,
    input  logic           rst,
    coef_bank_seq_if.slave bus
);
    localparam int IW = (NCOEF  > 1) ? $clog2(NCOEF)  : 1;
    localparam int BW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

    localparam logic [IW:0]   NCOEF_L  = (IW+1)'(NCOEF);
    localparam logic [BW:0]   NBANDS_L = (BW+1)'(NBANDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Power-on / reset contents: b0 of bands 1..3 set, everything else zero.
    function automatic logic [WIDTH-1:0] f_default(input int band, input int idx);
        logic [WIDTH-1:0] v;
        v = '0;
        if (idx == 0) begin
            case (band)
                1:       v = WIDTH'(32'd3);
                2:       v = WIDTH'(32'd1362);
                3:       v = WIDTH'(32'd13323);
                default: v = '0;
            endcase
        end else begin
            v = '0;
        end
        return v;
    endfunction

    logic [WIDTH-1:0] r_table [NBANDS][NCOEF];

    state_t           r_state;
    logic [BW-1:0]    r_band;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_done;

    logic             w_wr_ok;
    logic             w_accept;
    logic [IW-1:0]    w_next_idx;
    logic [BW-1:0]    w_rd_band;
    logic [IW-1:0]    w_rd_idx;
    logic [WIDTH-1:0] w_rd_data;

    // Write qualification, handshake and table read for the beat about to be loaded.
    always_comb begin
        w_wr_ok    = bus.wr_en
                   & ({1'b0, bus.wr_band} < NBANDS_L)
                   & ({1'b0, bus.wr_idx}  < NCOEF_L);
        w_accept   = r_valid & bus.coef_ready;
        w_next_idx = r_idx + IDX_ONE;
        // Idle loads index 0 of the requested band; running loads the next index.
        if (r_state == S_IDLE) begin
            w_rd_band = bus.sel;
            w_rd_idx  = '0;
        end else begin
            w_rd_band = r_band;
            w_rd_idx  = w_next_idx;
        end
        if (({1'b0, w_rd_band} < NBANDS_L) && ({1'b0, w_rd_idx} < NCOEF_L)) begin
            w_rd_data = r_table[w_rd_band][w_rd_idx];
        end else begin
            w_rd_data = '0;
        end
        // A same-cycle write to the entry being loaded wins, so a write to a
        // not-yet-presented entry always shows up in the running frame.
        if (w_wr_ok && (bus.wr_band == w_rd_band) && (bus.wr_idx == w_rd_idx)) begin
            w_rd_data = bus.wr_data;
        end else begin
            w_rd_data = w_rd_data;
        end
    end

    // Coefficient table: defaults on reset, single write port otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANDS; b++) begin
                for (int i = 0; i < NCOEF; i++) begin
                    r_table[b][i] <= f_default(b, i);
                end
            end
        end else if (w_wr_ok) begin
            r_table[bus.wr_band][bus.wr_idx] <= bus.wr_data;
        end
    end

    // Sequencer FSM with registered stream and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_band  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_band  <= bus.sel;
                        r_idx   <= '0;
                        r_data  <= w_rd_data;
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Without an accept the beat is held untouched; table
                    // writes do not reach the already-loaded r_data.
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_data  <= w_rd_data;
                            r_last  <= (w_next_idx == LAST_IDX);
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coef_data  = r_data;
    assign bus.coef_idx   = r_idx;
    assign bus.coef_valid = r_valid;
    assign bus.coef_last  = r_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_coef_bank_seq.sv
// ---------------------------------------------------------------------------
// tb_coef_bank_seq
// Drives coef_bank_seq through directed scenarios and a randomized run, and
// compares every cycle against a frame-level reference model of the bank.
// ---------------------------------------------------------------------------
module tb_coef_bank_seq;
    localparam int WIDTH  = 22;
    localparam int NCOEF  = 5;
    localparam int NBANDS = 4;

    logic clk;
    logic rst;

    coef_bank_seq_if #(.WIDTH(WIDTH), .NCOEF(NCOEF), .NBANDS(NBANDS)) bus ();

    coef_bank_seq #(.WIDTH(WIDTH), .NCOEF(NCOEF), .NBANDS(NBANDS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the table as plain values plus the frame in progress.
    logic [WIDTH-1:0] mtab [NBANDS][NCOEF];
    int               m_band;
    int               ei;
    logic [WIDTH-1:0] ed;
    logic             ev, eb, edn;

    task automatic model_reset();
        for (int b = 0; b < NBANDS; b++)
            for (int i = 0; i < NCOEF; i++)
                mtab[b][i] = '0;
        mtab[1][0] = 22'd3;
        mtab[2][0] = 22'd1362;
        mtab[3][0] = 22'd13323;
        ev = 1'b0; eb = 1'b0; edn = 1'b0; ei = 0; ed = '0; m_band = 0;
    endtask

    // Packs the model's expected outputs: valid, idx, last, data, busy, done.
    function automatic logic [28:0] exp_vec();
        return {ev, 3'(ei), (ev && ei == NCOEF - 1), ed, eb, edn};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {bus.coef_valid, bus.coef_idx, bus.coef_last, bus.coef_data, bus.busy, bus.done};
    endfunction

    // One clock: the model consumes the inputs present at the edge, then
    // outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (bus.wr_en && int'(bus.wr_band) < NBANDS && int'(bus.wr_idx) < NCOEF)
                mtab[bus.wr_band][bus.wr_idx] = bus.wr_data;
            edn = 1'b0;
            if (ev) begin
                if (bus.coef_ready) begin
                    if (ei == NCOEF - 1) begin
                        ev = 1'b0; eb = 1'b0; edn = 1'b1;
                    end else begin
                        ei = ei + 1;
                        ed = mtab[m_band][ei];
                    end
                end
            end else if (bus.start) begin
                m_band = int'(bus.sel);
                ei = 0;
                ed = mtab[m_band][0];
                ev = 1'b1; eb = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.sel = '0; bus.coef_ready = 1'b0;
        bus.wr_en = 1'b0; bus.wr_band = '0; bus.wr_idx = '0; bus.wr_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        tick(); tick();
        n_total++;
        if (dut_vec() !== 29'd0) $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 29'd0);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_band3();
        logic [WIDTH-1:0] seen [$];
        logic [WIDTH-1:0] want [5];
        want = '{22'd13323, 22'd0, 22'd0, 22'd0, 22'd0};
        bus.sel = 2'd3; bus.start = 1'b1; bus.coef_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL band3 cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            else n_pass++;
            if (bus.coef_valid && bus.coef_ready) seen.push_back(bus.coef_data);
            tick();
        end
        n_total++;
        if (seen.size() != 5) $display("FAIL band3_beats got=%0d exp=5", seen.size());
        else begin
            n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_total++;
                if (seen[k] !== want[k]) $display("FAIL band3_val%0d got=%0d exp=%0d", k, seen[k], want[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int accepts = 0;
        bus.sel = 2'd1; bus.start = 1'b1; bus.coef_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL stall cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            else n_pass++;
            if (c < 3) begin
                n_total++;
                if (bus.coef_data !== 22'd3 || bus.coef_idx !== 3'd0)
                    $display("FAIL stall_hold got=%0d/%0d exp=3/0", bus.coef_data, bus.coef_idx);
                else n_pass++;
            end
            bus.coef_ready = (c >= 2);
            if (bus.coef_valid && bus.coef_ready) accepts++;
            tick();
        end
        n_total++;
        if (accepts != 5) $display("FAIL stall_accepts got=%0d exp=5", accepts);
        else n_pass++;
        bus.coef_ready = 1'b0;
    endtask

    task automatic test_write_midframe();
        logic [WIDTH-1:0] by_idx [NCOEF];
        bit wrote3 = 0, stalled = 0;
        for (int f = 0; f < 2; f++) begin
            bus.sel = 2'd2; bus.start = 1'b1; bus.coef_ready = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 0; c < 9; c++) begin
                n_total++;
                if (dut_vec() !== exp_vec()) $display("FAIL wr_frame%0d cyc%0d got=%h exp=%h", f, c, dut_vec(), exp_vec());
                else n_pass++;
                bus.wr_en = 1'b0; bus.coef_ready = 1'b1;
                if (f == 0 && ev && ei == 1 && !wrote3) begin
                    bus.wr_en = 1'b1; bus.wr_band = 2'd2; bus.wr_idx = 3'd3; bus.wr_data = 22'd777;
                    wrote3 = 1;
                end else if (f == 0 && ev && ei == 2 && !stalled) begin
                    bus.wr_en = 1'b1; bus.wr_band = 2'd2; bus.wr_idx = 3'd2; bus.wr_data = 22'd555;
                    bus.coef_ready = 1'b0;
                    stalled = 1;
                end
                if (bus.coef_valid && bus.coef_ready) by_idx[bus.coef_idx] = bus.coef_data;
                tick();
            end
            bus.wr_en = 1'b0;
            n_total++;
            if (by_idx[3] !== 22'd777) $display("FAIL wr_visible f%0d got=%0d exp=777", f, by_idx[3]);
            else n_pass++;
            n_total++;
            if (by_idx[2] !== ((f == 0) ? 22'd0 : 22'd555))
                $display("FAIL wr_held f%0d got=%0d exp=%0d", f, by_idx[2], (f == 0) ? 0 : 555);
            else n_pass++;
        end
        bus.coef_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        bus.start = 1'b1; bus.coef_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.sel = 2'($urandom_range(0, 3));
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL b2b cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            else n_pass++;
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        n_total++;
        if (dones < 5) $display("FAIL b2b_frames got=%0d exp>=5", dones);
        else n_pass++;
        for (int c = 0; c < 8; c++) tick();
        bus.coef_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        bus.wr_en = 1'b1; bus.wr_band = 2'd3; bus.wr_idx = 3'd0; bus.wr_data = 22'd999;
        tick();
        bus.wr_en = 1'b0;
        bus.sel = 2'd3; bus.start = 1'b1; bus.coef_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!(ev && ei == 2) && guard < 10) begin
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL rstmid_pre got=%h exp=%h", dut_vec(), exp_vec());
            else n_pass++;
            tick();
            guard++;
        end
        n_total++;
        if (bus.coef_idx !== 3'd2 || bus.coef_data !== 22'd0) $display("FAIL rstmid_at_idx2 got=%0d exp=2", bus.coef_idx);
        else n_pass++;
        rst = 1'b1;
        #1;
        model_reset();
        n_total++;
        if (dut_vec() !== 29'd0) $display("FAIL rstmid_async got=%h exp=%h", dut_vec(), 29'd0);
        else n_pass++;
        tick(); tick();
        rst = 1'b0;
        bus.sel = 2'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (bus.coef_valid !== 1'b1 || bus.coef_data !== 22'd13323)
            $display("FAIL rstmid_default got=%0d exp=13323", bus.coef_data);
        else n_pass++;
        for (int c = 0; c < 7; c++) begin
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL rstmid_post cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_band0();
        int zeros = 0;
        bus.sel = 2'd0; bus.start = 1'b1; bus.coef_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL band0 cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            else n_pass++;
            if (bus.coef_valid && bus.coef_data === 22'd0) zeros++;
            tick();
        end
        n_total++;
        if (zeros != 5) $display("FAIL band0_zeros got=%0d exp=5", zeros);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.sel        = 2'($urandom_range(0, 3));
            bus.coef_ready = ($urandom_range(0, 3) != 0);
            bus.wr_en      = ($urandom_range(0, 3) == 0);
            bus.wr_band    = 2'($urandom_range(0, 3));
            bus.wr_idx     = 3'($urandom_range(0, 7));
            bus.wr_data    = 22'($urandom);
            tick();
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL random cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_band3();
        test_stall();
        test_write_midframe();
        test_back_to_back();
        test_reset_midframe();
        test_band0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
